restoring_div_seq: RTL and testbench
====================================

Name: restoring_div_seq

Overview:
Iterative, bit-serial sequencer for the restoring-division datapath. It time-multiplexes a single subtract/restore stage over one quotient bit per clock instead of unrolling one stage per bit. It is used where area matters more than latency. It accepts a dividend/divisor pair over a valid/ready handshake and returns quotient, remainder and status over a second valid/ready handshake.

Parameters:
DW, 4, dividend width in bits.
VW, 2, divisor width in bits (VW < DW).
QW, DW-VW+1, quotient width; derived, not overridable.

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
rin  input  DW  dividend
div  input  VW  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
q  output  QW  quotient
rout  output  VW+1  remainder; MSB is always 0 for a valid result
dz  output  1  divide-by-zero flag
ovf  output  1  quotient does not fit in QW bits
abort  input  1  present only with DIV_ABORT_EN

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE; in_ready=1; out_valid=0; q=0; rout=0; dz=0; ovf=0.
- rst overrides everything, including mid-ITER and DONE with out_valid high. The in-flight result is discarded.
- States: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch rin into P (DW bits) and div into D; clear q.
  - Compute flags from the incoming operands:
    - dz = (div==0).
    - ovf = !dz && ((rin>>QW) >= div).
  - If dz or ovf: force q=all ones and rout=0, go to DONE.
  - Otherwise set step index i=QW-1 and go to ITER.
- ITER (in_ready=0):
  - Each cycle, compare T=(P>>i) against D using a VW+2-bit subtractor.
  - If T>=D: q[i]=1 and P=P-(D<<i). Otherwise q[i]=0 and P is unchanged (restore).
  - When i==0 after that step, rout=P[VW:0] and go to DONE; otherwise decrement i.
  - Exactly QW cycles are spent in ITER.
- DONE:
  - out_valid=1; q/rout/dz/ovf hold stable until out_valid&out_ready.
  - On handshake, go to IDLE (in_ready=1 the next cycle).
  - No bypass: a new operand is never accepted in the handshake cycle.
- Latency, measured from the accept edge to the first cycle with out_valid=1:
  - QW+1 clocks for a normal division.
  - 1 clock for dz or ovf.
- Throughput: one result per QW+2 cycles with out_ready held high.
- Outputs are registered; no combinational path from in_* to out_*.
- in_valid while in_ready=0 is ignored; the producer must hold its operands.

Optional Feature:
Macro DIV_ABORT_EN.
- Defined:
  - abort port exists. abort=1 in ITER or DONE returns to IDLE next cycle with out_valid=0; the result is dropped.
  - abort in IDLE has no effect.
  - If abort and out_ready are both high in DONE, abort wins and no handshake is counted.
- Undefined: no abort port; ITER always runs to completion.

Test Plan:
- Normal division: reset, rin=13, div=3, out_ready=1 -> q=4, rout=1, dz=0, ovf=0; out_valid first high 4 clocks after accept.
- Sweep: rin=7/div=3 -> q=2,rout=1; rin=9/div=2 -> q=4,rout=1; rin=0/div=1 -> q=0,rout=0. Then exhaustively sweep all (rin,div) with div!=0 and (rin>>3)<div against a reference model.
- Divide by zero: rin=5, div=0 -> dz=1, ovf=0, q=7, rout=0, out_valid 1 clock after accept.
- Overflow: rin=14, div=1 -> ovf=1, dz=0, q=7, rout=0, 1-clock latency.
- Backpressure and reset: rin=13/div=3 with out_ready low for 5 cycles -> q/rout stable, in_ready=0, new in_valid ignored. Release out_ready -> in_ready=1 next cycle. Assert rst for one cycle mid-ITER -> all outputs at reset values next cycle, no out_valid.
- Abort (DIV_ABORT_EN builds only): abort in 2nd ITER cycle -> IDLE next cycle, out_valid never asserted, next operation rin=9/div=2 yields q=4, rout=1.

Source files
------------

// File: rtl/restoring_div_seq_if.sv
// Handshake bundle for restoring_div_seq: an operand channel (in_*, rin, div)
// and a result channel (out_*, q, rout, dz, ovf). The divider takes the slave
// modport; the producer/consumer side takes the master modport.
interface restoring_div_seq_if #(
  parameter int DW = 4,
  parameter int VW = 2
);
  localparam int QW = DW - VW + 1;

  // Operand channel
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] rin;
  logic [VW-1:0] div;

  // Result channel
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] q;
  logic [VW:0]   rout;
  logic          dz;
  logic          ovf;

  modport master (
    output in_valid, rin, div, out_ready,
    input  in_ready, out_valid, q, rout, dz, ovf
  );

  modport slave (
    input  in_valid, rin, div, out_ready,
    output in_ready, out_valid, q, rout, dz, ovf
  );
endinterface

// File: rtl/restoring_div_seq.sv
// restoring_div_seq: bit-serial restoring divider. One shared subtract/restore
// stage produces one quotient bit per clock, MSB first, over QW cycles.
// Divide-by-zero and quotient overflow are detected at accept time and skip
// the iteration entirely.
//
// Optional feature: define DIV_ABORT_EN to add an 'abort' input that drops an
// in-flight or pending result and returns to IDLE.
//
// Reset is synchronous, active-high.
module restoring_div_seq #(
  parameter int DW = 4,          // dividend width
  parameter int VW = 2           // divisor width, must be < DW
) (
  input  logic                clk,
  input  logic                rst,
  restoring_div_seq_if.slave  bus
`ifdef DIV_ABORT_EN
  ,
  input  logic                abort
`endif
);

  // Quotient width is derived from the operand widths and is not a parameter.
  localparam int QW = DW - VW + 1;
  // Step index width; at least one bit even for a single-step quotient.
  localparam int IW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [DW-1:0] p_q,     p_d;      // partial remainder
  logic [VW-1:0] d_q,     d_d;      // latched divisor
  logic [QW-1:0] q_q,     q_d;      // quotient under construction / result
  logic [VW:0]   rout_q,  rout_d;   // final remainder
  logic          dz_q,    dz_d;
  logic          ovf_q,   ovf_d;
  logic [IW-1:0] i_q,     i_d;      // current quotient bit position

  // ---------------------------------------------------------------------------
  // Accept-time flag evaluation on the incoming operands
  // ---------------------------------------------------------------------------
  logic div_is_zero;
  logic div_ovf;

  assign div_is_zero = (bus.div == '0);
  // The quotient fits in QW bits only if rin < div * 2^QW.
  assign div_ovf     = !div_is_zero && ((bus.rin >> QW) >= DW'(bus.div));

  // ---------------------------------------------------------------------------
  // Shared subtract/restore stage
  // ---------------------------------------------------------------------------
  // Because the overflow check guarantees P < D << (i+1) on entry to every
  // step, the window T = P >> i is always below 2*D and fits in VW+1 bits.
  // One extra bit on top carries the borrow, giving a VW+2-bit subtractor.
  logic [VW+1:0] t_win;
  logic [VW+1:0] t_diff;
  logic          t_borrow;
  logic [DW-1:0] low_mask;
  logic [DW-1:0] p_sub;

  assign t_win    = (VW+2)'(p_q >> i_q);
  assign t_diff   = t_win - {2'b00, d_q};
  assign t_borrow = t_diff[VW+1];

  // P - (D << i): bits below i are untouched, the window is replaced by the
  // difference, and everything above the window is already zero.
  assign low_mask = (DW'(1) << i_q) - DW'(1);
  assign p_sub    = (p_q & low_mask) | (DW'(t_diff[VW:0]) << i_q);

  // ---------------------------------------------------------------------------
  // Next-state and datapath update logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable is given its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    d_d     = d_q;
    q_d     = q_q;
    rout_d  = rout_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    i_d     = i_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          p_d    = bus.rin;
          d_d    = bus.div;
          q_d    = '0;
          rout_d = '0;
          dz_d   = div_is_zero;
          ovf_d  = div_ovf;
          if (div_is_zero || div_ovf) begin
            // Saturated quotient, no iteration.
            q_d     = '1;
            state_d = DONE;
          end else begin
            i_d     = IW'(QW - 1);
            state_d = ITER;
          end
        end
      end

      ITER: begin
        // q[i] was cleared on accept, so only the "fits" case needs a write.
        if (!t_borrow) begin
          q_d[i_q] = 1'b1;
          p_d      = p_sub;
        end
        if (i_q == '0) begin
          rout_d  = p_d[VW:0];
          state_d = DONE;
        end else begin
          i_d = i_q - 1'b1;
        end
      end

      DONE: begin
        // Result held until consumed; the handshake cycle never accepts.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef DIV_ABORT_EN
    // Abort beats a simultaneous result handshake; ignored while idle.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Register update with synchronous reset
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      rout_q  <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      q_q     <= q_d;
      rout_q  <= rout_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      i_q     <= i_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, no input-to-output path
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.rout      = rout_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  // A valid remainder is always below the divisor, so its MSB is clear.
  a_rout_msb_zero: assert property (@(posedge clk) disable iff (rst)
    bus.out_valid |-> !bus.rout[VW]);

  // The two channels are never open at the same time.
  a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.in_ready && bus.out_valid));

  // Flags are mutually exclusive.
  a_flags_excl: assert property (@(posedge clk) disable iff (rst)
    !(dz_q && ovf_q));

endmodule

// File: tb/tb_restoring_div_seq.sv
// Self-checking bench for restoring_div_seq: directed cases, an exhaustive
// sweep of in-range operands, randomized operations with random result
// backpressure, throughput, reset mid-iteration and (when built with
// DIV_ABORT_EN) abort.
module tb_restoring_div_seq;

  localparam int DW = 4;
  localparam int VW = 2;
  localparam int QW = DW - VW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  restoring_div_seq_if #(.DW(DW), .VW(VW)) bus ();

`ifdef DIV_ABORT_EN
  logic abort = 1'b0;
`endif

  restoring_div_seq #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DIV_ABORT_EN
    ,
    .abort (abort)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: plain integer division with the saturation rules.
  task automatic model(input int a, input int b,
                       output int eq, output int er, output int edz,
                       output int eovf, output int elat);
    edz = 0; eovf = 0;
    if (b == 0) begin
      edz = 1; eq = (1 << QW) - 1; er = 0; elat = 1;
    end else if (a / b >= (1 << QW)) begin
      eovf = 1; eq = (1 << QW) - 1; er = 0; elat = 1;
    end else begin
      eq = a / b; er = a % b; elat = QW + 1;
    end
  endtask

  // One full operation, called at a negedge; hold = cycles of out_ready low
  // after out_valid rises.
  task automatic run_op(input int a, input int b, input int hold);
    int eq, er, edz, eovf, elat;
    int lat;
    int n;
    logic [31:0] av, bv;
    av = a; bv = b;
    model(a, b, eq, er, edz, eovf, elat);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_op", 32'(bus.in_ready), 1);
    bus.rin       = av[DW-1:0];
    bus.div       = bv[VW-1:0];
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("lat %0d/%0d", a, b), lat, elat);
    check($sformatf("q %0d/%0d", a, b), 32'(bus.q), eq);
    check($sformatf("rout %0d/%0d", a, b), 32'(bus.rout), er);
    check($sformatf("dz %0d/%0d", a, b), 32'(bus.dz), edz);
    check($sformatf("ovf %0d/%0d", a, b), 32'(bus.ovf), eovf);
    check("ready_in_done", 32'(bus.in_ready), 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_q", 32'(bus.q), eq);
      check("hold_rout", 32'(bus.rout), er);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 32'(bus.out_valid), 0);
    check("post_hs_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_q"},         32'(bus.q), 0);
    check({tag, "_rout"},      32'(bus.rout), 0);
    check({tag, "_dz"},        32'(bus.dz), 0);
    check({tag, "_ovf"},       32'(bus.ovf), 0);
  endtask

  initial begin
    int acc[$];
    int cyc;
    int seen;

    bus.in_valid  = 1'b0;
    bus.rin       = '0;
    bus.div       = '0;
    bus.out_ready = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle");

    // Directed cases
    run_op(13, 3, 0);
    run_op(7, 3, 0);
    run_op(9, 2, 0);
    run_op(0, 1, 0);
    run_op(5, 0, 0);      // divide by zero
    run_op(14, 1, 0);     // overflow
    run_op(15, 0, 2);
    run_op(8, 1, 1);      // smallest overflow for div=1

    // Exhaustive sweep of non-saturating operands
    for (int a = 0; a < (1 << DW); a++)
      for (int b = 1; b < (1 << VW); b++)
        if ((a >> QW) < b) run_op(a, b, 0);

    // Backpressure: result held 5 cycles, new operands ignored meanwhile
    bus.rin = 4'd13; bus.div = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, QW + 1);
    bus.rin = 4'd5; bus.div = 2'd0; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_q", 32'(bus.q), 4);
      check("bp_rout", 32'(bus.rout), 1);
      check("bp_dz", 32'(bus.dz), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.in_ready), 1);
    check("bp_release_valid", 32'(bus.out_valid), 0);

    // Randomized operations with random backpressure
    for (int n = 0; n < 60; n++)
      run_op(int'($urandom_range(0, (1 << DW) - 1)),
             int'($urandom_range(0, (1 << VW) - 1)),
             int'($urandom_range(0, 3)));

    // Throughput: operands always offered, result always accepted
    bus.rin = 4'd13; bus.div = 2'd3; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    cyc = 0;
    while (acc.size() < 3 && cyc < 60) begin
      if (bus.in_valid && bus.in_ready) acc.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("tp_accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      check("tp_interval1", acc[1] - acc[0], QW + 2);
      check("tp_interval2", acc[2] - acc[1], QW + 2);
    end
    repeat (QW + 3) @(negedge clk);
    check("tp_drained", 32'(bus.in_ready), 1);

    // Synchronous reset in the middle of an iteration
    bus.rin = 4'd13; bus.div = 2'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_busy", 32'(bus.in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("mid_rst");
    seen = 0;
    for (int k = 0; k < QW + 3; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("mid_rst_no_valid", seen, 0);
    run_op(13, 3, 0);

`ifdef DIV_ABORT_EN
    // Abort in the second ITER cycle
    bus.rin = 4'd13; bus.div = 2'd3; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'(bus.in_ready), 1);
    check("abort_valid", 32'(bus.out_valid), 0);
    seen = 0;
    for (int k = 0; k < QW + 3; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    run_op(9, 2, 0);

    // Abort wins over a simultaneous handshake in DONE
    bus.rin = 4'd5; bus.div = 2'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_idle", 32'(bus.in_ready), 1);
    check("abort_done_valid", 32'(bus.out_valid), 0);
    run_op(7, 3, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
